// File: rtl/wb_lsu_pkg.sv
// Shared types and constants for the Wishbone load/store master bridge.
package wb_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RETRY,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_lsu_master_if.sv
// Core request/response channel plus Wishbone master bus, bundled for the bridge.
interface wb_lsu_master_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );

endinterface

// File: rtl/wb_lsu_align.sv
// Combinational lane logic: store byte-selects/replication, alignment check, load extract/extend.
module wb_lsu_align
    import wb_lsu_pkg::*;
(
    input  logic [1:0]  st_addr_lo_i,
    input  size_e       st_size_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_sel_o,
    output logic [31:0] st_dat_o,
    output logic        misaligned_o,
    input  logic [1:0]  ld_addr_lo_i,
    input  size_e       ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        st_sel_o     = 4'b0000;
        st_dat_o     = st_wdata_i;
        misaligned_o = 1'b0;
        case (st_size_i)
            SZ_BYTE: begin
                st_sel_o = 4'b0001 << st_addr_lo_i;
                st_dat_o = {4{st_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_sel_o     = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_dat_o     = {2{st_wdata_i[15:0]}};
                misaligned_o = st_addr_lo_i[0];
            end
            SZ_WORD: begin
                st_sel_o     = 4'b1111;
                misaligned_o = |st_addr_lo_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end

    assign ld_shift = ld_raw_i >> {ld_addr_lo_i, 3'b000};

    always_comb begin
        case (ld_size_i)
            SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data_o = ld_shift;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic master for the core LSU: one access at a time, rty re-issue and timeout abort.
module wb_lsu_master
    import wb_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_lsu_master_if.master  bus
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [1:0]  lo_q, lo_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [3:0]  st_sel;
    logic [31:0] st_dat;
    logic        misaligned;
    logic [31:0] ld_data;

    wb_lsu_align u_align (
        .st_addr_lo_i  (bus.req_addr_i[1:0]),
        .st_size_i     (size_e'(bus.req_size_i)),
        .st_wdata_i    (bus.req_wdata_i),
        .st_sel_o      (st_sel),
        .st_dat_o      (st_dat),
        .misaligned_o  (misaligned),
        .ld_addr_lo_i  (lo_q),
        .ld_size_i     (size_q),
        .ld_unsigned_i (uns_q),
        .ld_raw_i      (bus.wb_dat_i),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        lo_d        = lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    if (misaligned) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        adr_d   = {bus.req_addr_i[31:2], 2'b00};
                        dat_d   = st_dat;
                        sel_d   = st_sel;
                        we_d    = bus.req_we_i;
                        lo_d    = bus.req_addr_i[1:0];
                        size_d  = size_e'(bus.req_size_i);
                        uns_d   = bus.req_unsigned_i;
                        retry_d = '0;
                        tmo_d   = '0;
                    end
                end
            end
            ST_BUS: begin
                // Slave response priority: err, then ack, then rty.
                if (bus.wb_err_i) begin
                    state_d = ST_RESP;  cyc_d = 1'b0;
                    rsp_valid_d = 1'b1; rsp_err_d = 1'b1;
                end else if (bus.wb_ack_i) begin
                    state_d = ST_RESP;  cyc_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : ld_data;
                end else if (bus.wb_rty_i) begin
                    cyc_d = 1'b0;
                    if (retry_q < RETRY_MAX) begin
                        state_d = ST_RETRY;
                        retry_d = retry_q + 4'd1;
                    end else begin
                        state_d = ST_RESP;
                        rsp_valid_d = 1'b1; rsp_err_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RESP;  cyc_d = 1'b0;
                    rsp_valid_d = 1'b1; rsp_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_RETRY: begin
                state_d = ST_BUS;
                cyc_d   = 1'b1;
                tmo_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            lo_q        <= '0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            retry_q     <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_cti_o    = CTI_CLASSIC;
    assign bus.wb_bte_o    = BTE_LINEAR;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Randomised bench for wb_lsu_master against a transaction-level outcome/latency model.
module tb_wb_lsu_master;

    localparam int TMO  = 8;
    localparam int MAXR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_lsu_master_if bus ();

    wb_lsu_master #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] raw, input logic [1:0] lo,
                                                input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = raw >> (8 * lo);
        case (sz)
            2'd0:    return uns ? (s & 32'hFF)   : ((s & 32'hFF)   ^ 32'h80)   - 32'h80;
            2'd1:    return uns ? (s & 32'hFFFF) : ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            default: return raw;
        endcase
    endfunction

    // fin: 0 = ack, 1 = err, 2 = silent slave. n_rty rty answers precede the final one.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                           input logic [1:0] sz, input logic uns, input logic [31:0] wdata,
                           input logic [31:0] raw, input int n_rty, input int wt, input int fin);
        logic        legal, e_err;
        logic [3:0]  e_sel;
        logic [31:0] e_dat, e_rd;
        int          nbytes, e_att, e_lat, cnt, att, bus_c, gap;
        bit          prev_cyc, done;

        legal  = (sz == 2'd0) || (sz == 2'd1 && !addr[0]) || (sz == 2'd2 && addr[1:0] == 2'd0);
        nbytes = 1 << sz;
        e_sel  = 4'(((1 << nbytes) - 1) << addr[1:0]);
        e_dat  = (sz == 2'd0) ? (wdata & 32'hFF) * 32'h0101_0101 :
                 (sz == 2'd1) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        if (!legal) begin
            e_err = 1'b1; e_att = 0; e_lat = 1;
        end else if (n_rty > MAXR) begin
            e_err = 1'b1; e_att = MAXR + 1; e_lat = 1 + e_att * (wt + 1) + MAXR;
        end else begin
            e_err = (fin != 0); e_att = n_rty + 1;
            e_lat = 1 + n_rty * (wt + 2) + ((fin == 2) ? TMO : wt + 1);
        end
        e_rd = (e_err || we) ? 32'h0 : model_rdata(raw, addr[1:0], sz, uns);

        @(negedge clk);
        check({tag, ":ready"}, 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = addr;
        bus.req_we_i       = we;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_wdata_i    = wdata;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;
        bus.req_wdata_i = $urandom;
        bus.req_size_i  = 2'($urandom_range(0, 3));

        cnt = 1; att = 0; bus_c = 0; gap = 0; prev_cyc = 1'b0; done = 1'b0;
        while (!done && cnt < 200) begin
            bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
            bus.wb_dat_i = $urandom;
            if (bus.rsp_valid_o) begin
                check({tag, ":latency"},  32'(cnt), 32'(e_lat));
                check({tag, ":attempts"}, 32'(att), 32'(e_att));
                check({tag, ":err"},      32'(bus.rsp_err_o), 32'(e_err));
                check({tag, ":rdata"},    bus.rsp_rdata_o, e_rd);
                check({tag, ":cyc_rsp"},  32'(bus.wb_cyc_o), 32'd0);
                if (legal && n_rty <= MAXR && fin == 2)
                    check({tag, ":tmo_cycles"}, 32'(bus_c), 32'(TMO));
                done = 1'b1;
            end else if (bus.wb_cyc_o) begin
                if (!prev_cyc) begin
                    att++; bus_c = 0;
                    if (att > 1) check({tag, ":retry_gap"}, 32'(gap), 32'd1);
                    check({tag, ":adr"}, bus.wb_adr_o, addr & 32'hFFFF_FFFC);
                    check({tag, ":sel"}, 32'(bus.wb_sel_o), 32'(e_sel));
                    check({tag, ":dat"}, bus.wb_dat_o, e_dat);
                    check({tag, ":we"},  32'(bus.wb_we_o), 32'(we));
                    check({tag, ":stb_ready_cti"},
                          {24'd0, bus.wb_stb_o, bus.req_ready_o, bus.wb_cti_o, bus.wb_bte_o},
                          {24'd0, 1'b1, 1'b0, 3'b000, 2'b00});
                end
                bus_c++;
                if (bus_c == wt + 1) begin
                    if (att <= n_rty) begin
                        bus.wb_rty_i = 1'b1;
                    end else if (fin == 0) begin
                        bus.wb_ack_i = 1'b1; bus.wb_dat_i = raw;
                        bus.wb_rty_i = 1'($urandom_range(0, 1));
                    end else if (fin == 1) begin
                        bus.wb_err_i = 1'b1;
                        bus.wb_ack_i = 1'($urandom_range(0, 1));
                        bus.wb_rty_i = 1'($urandom_range(0, 1));
                    end
                end
                gap = 0;
            end else begin
                gap++;
            end
            prev_cyc = bus.wb_cyc_o;
            @(negedge clk);
            cnt++;
        end
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        if (!done) check({tag, ":rsp_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bit seen;
        bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_we_i = 1'b0;
        bus.req_size_i = 2'd0;  bus.req_unsigned_i = 1'b0; bus.req_wdata_i = '0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        #12;
        check("rst_wb", {bus.wb_adr_o | bus.wb_dat_o},
              32'h0);
        check("rst_ctl", {21'd0, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o,
                          bus.wb_cti_o, bus.wb_bte_o}, 32'h0);
        check("rst_rsp", {30'd0, bus.rsp_valid_o, bus.rsp_err_o} | bus.rsp_rdata_o, 32'h0);
        check("rst_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("lw",       32'h10, 1'b0, 2'd2, 1'b0, 32'h0,      32'hDEADBEEF, 0, 0, 0);
        run_txn("lb",       32'h13, 1'b0, 2'd0, 1'b0, 32'h0,      32'h80A5_5A11, 0, 0, 0);
        run_txn("lbu",      32'h13, 1'b0, 2'd0, 1'b1, 32'h0,      32'h80A5_5A11, 0, 0, 0);
        run_txn("sh",       32'h02, 1'b1, 2'd1, 1'b0, 32'h1234,   32'h0,        0, 0, 0);
        run_txn("lw_mis",   32'h06, 1'b0, 2'd2, 1'b0, 32'h0,      32'h0,        0, 0, 0);
        run_txn("size11",   32'h20, 1'b0, 2'd3, 1'b0, 32'h0,      32'h0,        0, 0, 0);
        run_txn("rty2_ack", 32'h44, 1'b0, 2'd2, 1'b0, 32'h0,      32'h1357_9BDF, 2, 0, 0);
        run_txn("rty_all",  32'h48, 1'b1, 2'd2, 1'b0, 32'hCAFE,   32'h0,        9, 0, 0);
        run_txn("timeout",  32'h4C, 1'b0, 2'd2, 1'b0, 32'h0,      32'h0,        0, 0, 2);
        run_txn("slv_err",  32'h51, 1'b0, 2'd0, 1'b0, 32'h0,      32'h0,        0, 1, 1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          nr, fin;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
            nr  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 0;
            fin = ($urandom_range(0, 5) == 0) ? 2 : ($urandom_range(0, 4) == 0) ? 1 : 0;
            run_txn("rand", a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    $urandom, $urandom, nr, int'($urandom_range(0, 3)), fin);
        end

        // Asynchronous reset while a silent slave holds the bridge in BUS.
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h80; bus.req_size_i = 2'd2; bus.req_we_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_bus_cyc", 32'(bus.wb_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_drop", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid_o | bus.wb_cyc_o;
        end
        check("rst_no_rsp", 32'(seen), 32'd0);
        check("rst_ready_after", 32'(bus.req_ready_o), 32'd1);
        run_txn("post_rst", 32'h84, 1'b0, 2'd1, 1'b1, 32'h0, 32'h8001_F00F, 0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
Wishbone classic-cycle master bridge between the RV32I core load/store unit and the IO port of the Wishbone interconnect. It accepts one core load/store request at a time and performs the following steps:
- generates byte lanes and replicated write data,
- runs a single Wishbone cycle, with retry on rty and a timeout,
- returns a one-cycle response with aligned, sign/zero-extended load data or an error flag.

Misaligned and illegal accesses are rejected locally, without a bus cycle.

Parameters:
TIMEOUT_CYCLES, 255, BUS-state cycles without ack/err/rty before the access is aborted with error (1..65535)
MAX_RETRY, 3, number of re-issues allowed after rty before error (0..15)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  core request valid
req_ready_o  out  1  bridge can accept a request (high only in IDLE)
req_addr_i  in  32  byte address
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  in  1  zero-extend loads (LBU/LHU)
req_wdata_i  in  32  store data, right-aligned
rsp_valid_o  out  1  one-cycle response strobe
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  access faulted (qualified by rsp_valid_o)
wb_adr_o  out  32  word address {addr[31:2],2'b00}
wb_dat_o  out  32  write data, lane-replicated
wb_sel_o  out  4  byte select
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  constant 3'b000 (classic)
wb_bte_o  out  2  constant 2'b00
wb_dat_i  in  32  read data
wb_ack_i  in  1  slave ack
wb_err_i  in  1  slave error
wb_rty_i  in  1  slave retry

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: all wb_* outputs 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1, state IDLE, counters 0.
  - All outputs are registered except req_ready_o, which is decoded from state.
- States: IDLE, BUS, RETRY, RESP.
- IDLE:
  - req_ready_o=1; a request is accepted when req_valid_i is high.
  - Illegal request (size 11, half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1. No bus activity.
  - Legal request: latch address, size, unsigned, we, sel and data. Set cyc=stb=1 the next cycle and go to BUS. Clear retry and timeout counters.
- Lane generation:
  - byte: sel=4'b0001<<addr[1:0], dat={4{wdata[7:0]}}
  - half: sel=addr[1]?4'b1100:4'b0011, dat={2{wdata[15:0]}}
  - word: sel=4'b1111, dat=wdata
  - sel is driven for loads as well.
- BUS (cyc=stb=1, held stable), response priority err > ack > rty:
  - err: drop cyc/stb, go to RESP with err=1.
  - ack: capture wb_dat_i, drop cyc/stb, go to RESP with err=0.
  - rty with retry_cnt<MAX_RETRY: drop cyc/stb, retry_cnt++, go to RETRY.
  - rty with retry_cnt==MAX_RETRY: drop cyc/stb, go to RESP with err=1.
  - Otherwise timeout_cnt++. When timeout_cnt reaches TIMEOUT_CYCLES-1: drop cyc/stb, go to RESP with err=1.
- RETRY: exactly one cycle with cyc=stb=0. Then re-assert with identical adr/dat/sel/we, clear timeout_cnt, go to BUS.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then IDLE.
  - Load data: shift captured data right by 8*addr[1:0], then sign- or zero-extend from bit 7 (byte) or bit 15 (half).
  - rsp_rdata_o=0 on store or error.
  - The core must always accept the response; there is no rsp backpressure.
- Latency: request accepted at cycle N, cyc/stb high at N+1. A zero-wait ack at N+1 gives rsp_valid_o at N+2. A rejected request gives rsp_valid_o at N+1.
- Requests are not accepted in BUS, RETRY or RESP. req_* inputs are ignored outside IDLE.
- Asynchronous reset mid-cycle drops cyc/stb immediately. No response is produced for the in-flight access.

Decomposition:
- Package wb_lsu_pkg:
  - state enum (IDLE, BUS, RETRY, RESP)
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - constants CTI_CLASSIC=3'b000 and BTE_LINEAR=2'b00
- Sub-module wb_lsu_align (combinational):
  - store lane and data generation
  - misalignment check
  - load shift and extension
- The top module holds the FSM and the counters.

Test Plan:
- LW from addr 0x0000_0010, slave acks at first cycle with 0xDEADBEEF -> wb_sel_o=4'hF, wb_adr_o=0x10; rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid_o two cycles after acceptance.
- LB at 0x0000_0013 with wb_dat_i=0x80xx_xxxx -> sel=4'b1000, rsp_rdata_o=0xFFFF_FF80; the same access as LBU returns 0x0000_0080.
- SH of wdata 0x0000_1234 at 0x0000_0002 -> wb_dat_o=0x1234_1234, sel=4'b1100, we=1; response err=0, rdata=0.
- LW at 0x0000_0006 -> no cyc ever asserted, rsp_valid_o with err=1 the next cycle; also check size=11 -> err.
- Slave answers rty twice then ack (MAX_RETRY=3) -> cyc low for exactly one cycle between attempts, identical adr/sel, final err=0. Slave always rty -> 4 bus attempts, then err=1.
- No slave response, TIMEOUT_CYCLES=8 -> cyc/stb drop after 8 BUS cycles, err=1. Assert wb_rst_n_i mid-BUS -> cyc=0 immediately and no rsp_valid_o.
